// File: rtl/quad_pkg.sv
// Shared phase encoding, step classification and default parameters
// for the quadrature decoder.
package quad_pkg;

  localparam logic [1:0] P0 = 2'b00;
  localparam logic [1:0] P1 = 2'b01;
  localparam logic [1:0] P3 = 2'b11;
  localparam logic [1:0] P2 = 2'b10;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILT_CYCLES = 4;

  typedef enum logic [1:0] {
    DIR_NONE    = 2'd0,
    DIR_FWD     = 2'd1,
    DIR_REV     = 2'd2,
    DIR_ILLEGAL = 2'd3
  } dir_e;

  // Forward order is P0 -> P1 -> P3 -> P2 -> P0.
  function automatic logic [1:0] fwd_next(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      P0:      nxt = P1;
      P1:      nxt = P3;
      P3:      nxt = P2;
      default: nxt = P0;
    endcase
    return nxt;
  endfunction

  function automatic dir_e step_dir(input logic [1:0] old_ph, input logic [1:0] new_ph);
    dir_e d;
    if (old_ph == new_ph)                d = DIR_NONE;
    else if (new_ph == fwd_next(old_ph)) d = DIR_FWD;
    else if (old_ph == fwd_next(new_ph)) d = DIR_REV;
    else                                 d = DIR_ILLEGAL;
    return d;
  endfunction

endpackage

// File: rtl/glitch_filter.sv
// One encoder channel: multi-stage synchroniser followed by a stability
// filter that accepts a new level only after FILT_CYCLES consecutive samples.
module glitch_filter
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_CYCLES = DEF_FILT_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic level_o
);

  localparam int CNT_W = $clog2(FILT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   synced;

  assign synced  = sync_q[SYNC_STAGES-1];
  assign level_o = level_q;

  // The count hitting FILT_CYCLES-1 plus this differing sample makes FILT_CYCLES.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (synced == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(FILT_CYCLES - 1)) begin
      level_d = synced;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder front end: filters A/B, tracks the Gray-code phase and
// emits registered inc/dec step pulses plus a sticky illegal-step flag.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_CYCLES = DEF_FILT_CYCLES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       en,
  input  logic       err_clr,
  output logic       inc,
  output logic       dec,
  output logic       err,
  output logic [1:0] phase
);

  logic       a_lvl, b_lvl;
  logic [1:0] acc;
  dir_e       dir;

  logic [1:0] phase_q, phase_d;
  logic       primed_q, primed_d;
  logic       inc_q, inc_d;
  logic       dec_q, dec_d;
  logic       err_q, err_d;

  glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_filt_a (
    .clk     (clk),
    .reset_n (reset_n),
    .raw_i   (enc_a),
    .level_o (a_lvl)
  );

  glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_filt_b (
    .clk     (clk),
    .reset_n (reset_n),
    .raw_i   (enc_b),
    .level_o (b_lvl)
  );

  assign acc = {a_lvl, b_lvl};
  assign dir = step_dir(phase_q, acc);

  // The first accepted change after reset only primes the tracker.
  always_comb begin
    phase_d  = phase_q;
    primed_d = primed_q;
    inc_d    = 1'b0;
    dec_d    = 1'b0;
    err_d    = err_q & ~err_clr;
    if (acc != phase_q) begin
      phase_d  = acc;
      primed_d = 1'b1;
      if (primed_q && en) begin
        inc_d = (dir == DIR_FWD);
        dec_d = (dir == DIR_REV);
        if (dir == DIR_ILLEGAL) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q  <= P0;
      primed_q <= 1'b0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      primed_q <= primed_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      err_q    <= err_d;
    end
  end

  assign inc   = inc_q;
  assign dec   = dec_q;
  assign err   = err_q;
  assign phase = phase_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder: each driven step queues its expected
// output event, and a negedge monitor pops and checks events as they appear.
module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enc_a = 1'b0;
  logic       enc_b = 1'b0;
  logic       en = 1'b1;
  logic       err_clr = 1'b0;
  logic       inc, dec, err;
  logic [1:0] phase;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         kind;   // 1 = inc, 2 = dec, 3 = err rise
    int         due;
    logic [1:0] ph;
  } ev_t;

  ev_t        sb[$];
  ev_t        mon_ev;
  int         mon_kind;
  logic [1:0] m_phase = 2'b00;
  bit         m_primed = 1'b0;
  logic       err_prev = 1'b0;

  quad_decoder #(.SYNC_STAGES(2), .FILT_CYCLES(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enc_a   (enc_a),
    .enc_b   (enc_b),
    .en      (en),
    .err_clr (err_clr),
    .inc     (inc),
    .dec     (dec),
    .err     (err),
    .phase   (phase)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [1:0] gray_fwd(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a new {A,B}, queue the expected event, then hold it for 'hold' cycles.
  // err_clr is pulsed during the edge clr_at+1 cycles after the drive (-1 = never).
  task automatic step(input logic [1:0] ab, input int hold, input int clr_at);
    int kind;
    {enc_a, enc_b} = ab;
    if (ab != m_phase) begin
      if (!m_primed) begin
        m_primed = 1'b1;
      end else if (en) begin
        if (ab == gray_fwd(m_phase))      kind = 1;
        else if (m_phase == gray_fwd(ab)) kind = 2;
        else                              kind = 3;
        sb.push_back('{kind, cyc + 7, ab});
      end
      m_phase = ab;
    end
    $display("step ab=%b en=%b cyc=%0d queued=%0d", ab, en, cyc, sb.size());
    for (int i = 0; i < hold; i++) begin
      if (i == clr_at) err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && (inc || dec || (err && !err_prev))) begin
      chk("exclusive", {31'b0, inc & dec}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_out", {29'b0, inc, dec, err}, 32'd0);
      end else begin
        mon_ev   = sb.pop_front();
        mon_kind = inc ? 1 : (dec ? 2 : 3);
        chk("kind", mon_kind, mon_ev.kind);
        chk("latency", cyc, mon_ev.due);
        chk("phase_at_pulse", {30'b0, phase}, {30'b0, mon_ev.ph});
      end
    end
    err_prev <= err;
  end

  initial begin
    enc_a = 1'b1;
    enc_b = 1'b1;
    tick(3);
    chk("rst_inc", {31'b0, inc}, 32'd0);
    chk("rst_dec", {31'b0, dec}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_phase", {30'b0, phase}, 32'd0);

    // Release with 11 held: tracker primes on edge 7, no pulse.
    reset_n  = 1'b1;
    m_phase  = 2'b11;
    m_primed = 1'b1;
    tick(6);
    chk("prime_early", {30'b0, phase}, 32'd0);
    tick(1);
    chk("prime_phase", {30'b0, phase}, 32'd3);
    tick(13);

    step(2'b10, 20, -1);
    step(2'b00, 20, -1);

    // Forward sweep
    step(2'b01, 20, -1);
    step(2'b11, 20, -1);
    step(2'b10, 20, -1);
    step(2'b00, 20, -1);

    // Reverse sweep with a 3-cycle glitch on A
    step(2'b10, 20, -1);
    step(2'b11, 20, -1);
    enc_a = 1'b0;
    tick(3);
    enc_a = 1'b1;
    tick(12);
    chk("glitch_phase", {30'b0, phase}, 32'd3);
    step(2'b01, 20, -1);
    step(2'b00, 20, -1);

    // Illegal double step, clear, then clear coinciding with a new error
    step(2'b11, 20, -1);
    chk("err_set", {31'b0, err}, 32'd1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("err_cleared", {31'b0, err}, 32'd0);
    step(2'b00, 20, 6);
    chk("err_set_wins", {31'b0, err}, 32'd1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("err_cleared2", {31'b0, err}, 32'd0);

    // Enable gating
    en = 1'b0;
    step(2'b01, 20, -1);
    step(2'b11, 20, -1);
    step(2'b10, 20, -1);
    chk("en_phase", {30'b0, phase}, 32'd2);
    en = 1'b1;
    step(2'b00, 20, -1);

    // Async reset while an A edge is mid-filter
    step(2'b11, 20, -1);
    chk("pre_rst_err", {31'b0, err}, 32'd1);
    {enc_a, enc_b} = 2'b01;
    tick(4);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_inc", {31'b0, inc}, 32'd0);
    chk("async_dec", {31'b0, dec}, 32'd0);
    chk("async_err", {31'b0, err}, 32'd0);
    chk("async_phase", {30'b0, phase}, 32'd0);
    chk("sb_before_rst", sb.size(), 32'd0);
    tick(2);
    reset_n  = 1'b1;
    m_phase  = 2'b01;
    m_primed = 1'b1;
    tick(20);
    chk("reprime_phase", {30'b0, phase}, 32'd1);
    step(2'b11, 20, -1);

    tick(5);
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature encoder front end that turns raw A/B encoder lines into single-cycle `inc`/`dec` step pulses for the downstream up/down counter. It synchronises and glitch-filters both inputs, then tracks the Gray-code phase. Each legal phase step produces exactly one pulse, and each illegal double-step sets a sticky error. `inc` and `dec` are never high together, so the counter never has to arbitrate between them.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages in each input synchroniser; minimum 2.
- `FILT_CYCLES`, 4: consecutive identical synchronised samples needed before a channel level is accepted; minimum 1.
- `clk` input 1: single clock; all logic on the rising edge.
- `reset_n` input 1: reset is asynchronous and active-low. Assertion is asynchronous; release is synchronous to `clk`.
- `enc_a` input 1: encoder channel A, asynchronous to `clk`.
- `enc_b` input 1: encoder channel B, asynchronous to `clk`.
- `en` input 1: pulse enable. When 0, phase tracking continues but no pulses and no error are produced.
- `err_clr` input 1: synchronous clear of `err`.
- `inc` output 1: one-cycle pulse for each forward step.
- `dec` output 1: one-cycle pulse for each reverse step.
- `err` output 1: sticky flag for an illegal transition (both channels changed in one update).
- `phase` output 2: current accepted phase {A,B}, for debug.

## Operation
- **Reset values:** `inc`=0, `dec`=0, `err`=0, `phase`=2'b00. Synchroniser and filter registers reset to 0. The `primed` flag resets to 0.
- **Synchroniser:** per channel, a `SYNC_STAGES`-deep shift register.
- **Filter (per channel):**
  - A counter tracks how many consecutive cycles the synchronised level has differed from the accepted level.
  - The accepted level updates on the edge where that count reaches `FILT_CYCLES`.
  - Any return to the accepted level clears the counter.
  - Pulses shorter than `FILT_CYCLES` cycles are discarded.
- **Phase tracker:** states are Gray-coded {A,B}: P0=00, P1=01, P3=11, P2=10.
  - Forward (inc) order: 00→01→11→10→00.
  - Reverse (dec) order: the opposite direction.
- **On each cycle where the accepted {A,B} differs from `phase`:**
  - If `primed`=0: load `phase` and set `primed`=1. No pulse and no error; this is the first acceptance after reset.
  - Forward step: `inc`=1 for one cycle.
  - Reverse step: `dec`=1 for one cycle.
  - Both bits changed: set `err`. No pulse.
  - In every case `phase` takes the new value.
- **`en`=0:** `phase` and `primed` still update; `inc`, `dec` and `err` setting are suppressed. No pulse is deferred to when `en` returns high.
- **Error flag:** `err_clr` clears `err` on the next edge. If an error occurs in the same cycle as `err_clr`, set wins.
- **Simultaneous updates:** if both channels are accepted on the same edge, this is a double change and sets `err`. There is no arbitration.
- **Mid-operation reset:** asserting `reset_n` low returns everything to reset values immediately. Partially filtered edges are lost.

## Timing
- **Latency:** number the first `clk` edge that samples a new `enc_a`/`enc_b` level as edge 1. The pulse is high during the cycle after edge `SYNC_STAGES+FILT_CYCLES+1`. With defaults this is edge 7.
- `inc`/`dec` are registered outputs, high for exactly one cycle per step.
- **Maximum step rate:** one step per `FILT_CYCLES` cycles per channel. Faster input toggling is filtered out, not queued.
- `err` rises one cycle after the illegal acceptance, in the same position a pulse would have had.
- `phase` updates on the same edge as the corresponding pulse.

## Structure
- **Package `quad_pkg`:**
  - Phase constants P0..P3.
  - Function `step_dir(old,new)` returning NONE, FWD, REV or ILLEGAL.
  - Default parameter values.
- **Sub-module `glitch_filter`:** synchroniser plus stability filter for one channel, parameterised by `SYNC_STAGES`/`FILT_CYCLES`. It is instantiated twice.
- The top level holds the phase tracker, `primed`, the output registers and `err`.

## Test plan
- **Reset and prime:** release reset with A=1,B=1 held. Require `phase`=11 after edge 7 of sampling, and `inc`, `dec` and `err` all stay 0.
- **Forward sweep:** from phase 00, drive 01,11,10,00 with 20 cycles between steps. Require exactly 4 `inc` pulses, each 1 cycle wide and 7 cycles after its input change, with `dec`=0 throughout.
- **Reverse sweep and glitch:** drive 10,11,01,00 (4 `dec` pulses). Inject a 3-cycle pulse on A mid-sweep; it produces no pulse and `phase` is unchanged.
- **Illegal step:** with `phase`=00, switch A and B to 11 on the same cycle. Require `err`=1 and no pulse. Assert `err_clr` for 1 cycle → `err`=0. Then assert `err_clr` on the same cycle as a new illegal step → `err` stays 1.
- **Enable gating:** with `en`=0, drive 3 forward steps. Require no pulses and final `phase`=10. Set `en`=1 and step to 00 → exactly 1 `inc`.
- **Async reset mid-step:** assert `reset_n` low while an A edge is partway through filtering. Require all outputs to go to 0 immediately, and no pulse after release until the tracker primes.
